warmboot_ctrl: RTL

Sequences the iCE40 SB_WARMBOOT primitive for the USB bootloader, replacing the ad-hoc host-presence timer and direct BOOT OR-ing in the top level. It tracks SOF activity, accepts explicit boot requests from the SPI-bridge endpoint, and waits for the host's status-stage ACK. It then waits for a settle delay and for any SPI flash activity to finish before asserting BOOT with stable image-select bits. Sits at top level between usb_fs_pe / usb_spi_bridge_ep and SB_WARMBOOT.

---
 rtl/warmboot_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/warmboot_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// warmboot_ctrl : sequences SB_WARMBOOT (host timeout, boot request, ACK, settle)
// Revision 1.0
// ----------------------------------------------------------------------------
module warmboot_ctrl #(
  parameter int unsigned HOST_TIMEOUT_CYCLES = 48000000,
  parameter int unsigned ACK_TIMEOUT_CYCLES  = 480000,
  parameter int unsigned BOOT_DELAY_CYCLES   = 48000,
  parameter logic [1:0]  DEFAULT_IMAGE       = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sof_valid,
  input  logic       boot_req,
  input  logic [1:0] boot_image,
  input  logic       in_ep_acked,
  input  logic       boot_inhibit,
  output logic       warmboot_s1,
  output logic       warmboot_s0,
  output logic       warmboot_boot,
  output logic       host_present,
  output logic       boot_pending
);

  localparam logic [31:0] C_HOST_LAST = 32'(HOST_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] C_ACK_LAST  = 32'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] C_DLY_END   = 32'(BOOT_DELAY_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DELAY    = 2'd2,
    ST_FIRE     = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_timer;
  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_timer       <= '0;
      r_cnt         <= '0;
      warmboot_s1   <= DEFAULT_IMAGE[1];
      warmboot_s0   <= DEFAULT_IMAGE[0];
      warmboot_boot <= 1'b0;
      host_present  <= 1'b0;
      boot_pending  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (sof_valid) begin
            r_timer      <= '0;
            host_present <= 1'b1;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 32'd1;
          end
          // An explicit request outranks a host timeout in the same cycle.
          if (boot_req) begin
            {warmboot_s1, warmboot_s0} <= boot_image;
            r_cnt        <= '0;
            boot_pending <= 1'b1;
            r_state      <= ST_WAIT_ACK;
          end else if (!sof_valid && r_timer == C_HOST_LAST) begin
            {warmboot_s1, warmboot_s0} <= DEFAULT_IMAGE;
            host_present <= 1'b0;
            r_cnt        <= '0;
            boot_pending <= 1'b1;
            r_state      <= ST_DELAY;
          end
        end
        ST_WAIT_ACK: begin
          if (in_ep_acked || r_cnt == C_ACK_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DELAY;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_DELAY: begin
          // Counter parks at the settle value while flash activity holds us off.
          if (r_cnt == C_DLY_END) begin
            if (!boot_inhibit) begin
              warmboot_boot <= 1'b1;
              r_state       <= ST_FIRE;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_FIRE: begin
          warmboot_boot <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
